// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// Memory-mapped 8N1 UART transmitter: bus writes fill a circular TX FIFO, and an FSM
// serialises each byte on txd with a run-time programmable bit period of DIV+1 clocks.
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        ren,
   output logic [31:0] rdata,
   input  logic        wen,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        txd
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          txd_q;
   state_t        state_q;

   logic [1:0] sel;
   logic       full, empty, bit_done, pop, push_req, push_ok;
   logic       unused_bits;

   assign sel      = addr[3:2];
   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign bit_done = (cnt_q >= div_q);
   assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
   assign push_req = wen && (sel == 2'd0) && wstrb[0];
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req && (!full || pop);
   assign txd      = txd_q;
   assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16], wstrb[3:2]};

   always_comb begin
      ovf_d = ovf_q;
      if (wen && (sel == 2'd1) && wstrb[0] && wdata[3])
         ovf_d = 1'b0;
      if (push_req && full && !pop)
         ovf_d = 1'b1;
      div_d = div_q;
      if (wen && (sel == 2'd2)) begin
         if (wstrb[0]) div_d[7:0]  = wdata[7:0];
         if (wstrb[1]) div_d[15:8] = wdata[15:8];
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (ren) begin
         case (sel)
            2'd1:    rdata = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, state_q != IDLE};
            2'd2:    rdata = {16'h0, div_q};
            default: rdata = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= wdata[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         ovf_q <= ovf_d;
         div_q <= div_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               txd_q <= 1'b1;
               if (!empty) begin
                  shift_q <= mem_q[rd_ptr_q];
                  cnt_q   <= 16'd0;
                  state_q <= START;
                  txd_q   <= 1'b0;
               end
            end
            START: begin
               if (bit_done) begin
                  cnt_q   <= 16'd0;
                  bit_q   <= 3'd0;
                  state_q <= DATA;
                  txd_q   <= shift_q[0];
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  cnt_q   <= 16'd0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     txd_q <= shift_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  cnt_q <= 16'd0;
                  // Queued data goes straight into the next start bit with no idle gap.
                  if (!empty) begin
                     shift_q <= mem_q[rd_ptr_q];
                     state_q <= START;
                     txd_q   <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     txd_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
// Bench for mmio_uart_tx: a frame-level reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_mmio_uart_tx;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic        ren, wen, txd;
   logic [3:0]  wstrb;

   int n_checks = 0;
   int n_pass   = 0;

   mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .rst(rst), .addr(addr), .ren(ren), .rdata(rdata),
      .wen(wen), .wdata(wdata), .wstrb(wstrb), .txd(txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: byte queue plus the 10-bit frame currently on the line,
   // indexed by bit position and clocks spent in that bit.
   int          q[$];
   bit          m_busy;
   logic [9:0]  m_fr;
   int          m_pos, m_el;
   bit          m_ovf;
   logic [15:0] m_div;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_busy = 0; m_pos = 0; m_el = 0; m_ovf = 0; m_div = 16'd433; m_fr = '1;
      end else begin
         bit start_new;
         bit set_ovf;
         start_new = 0;
         set_ovf   = 0;
         if (!m_busy) start_new = (q.size() > 0);
         else if (m_el >= int'(m_div)) begin
            if (m_pos == 9) begin
               if (q.size() > 0) start_new = 1;
               else m_busy = 0;
            end else begin
               m_pos++;
               m_el = 0;
            end
         end else m_el++;
         if (start_new) begin
            m_fr   = {1'b1, 8'(q.pop_front()), 1'b0};
            m_pos  = 0;
            m_el   = 0;
            m_busy = 1;
         end
         if (wen) begin
            case (addr[3:2])
               2'd0: if (wstrb[0]) begin
                  if (q.size() < DEPTH) q.push_back(int'(wdata[7:0]));
                  else set_ovf = 1;
               end
               2'd1: if (wstrb[0] && wdata[3]) m_ovf = 0;
               2'd2: begin
                  if (wstrb[0]) m_div[7:0]  = wdata[7:0];
                  if (wstrb[1]) m_div[15:8] = wdata[15:8];
               end
               default: ;
            endcase
         end
         if (set_ovf) m_ovf = 1;
      end
   end

   function automatic logic exp_txd();
      return m_busy ? m_fr[m_pos] : 1'b1;
   endfunction

   function automatic logic [31:0] exp_rdata();
      if (!ren) return 32'h0;
      case (addr[3:2])
         2'd1:    return {16'h0, 8'(q.size()), 4'h0, m_ovf, q.size() == 0, q.size() == DEPTH, m_busy};
         2'd2:    return {16'h0, m_div};
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      check("txd_model", {31'h0, txd}, {31'h0, exp_txd()});
      check("rdata_model", rdata, exp_rdata());
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // Called 1ns after an edge; the write is sampled on the next edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      addr = a; wdata = d; wstrb = s; wen = 1'b1;
      @(posedge clk); #1;
      $display("wr addr=%h data=%h strb=%b", a, d, s);
      wen = 1'b0; wstrb = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      addr = a; ren = 1'b1;
      #1;
      v = rdata;
      ren = 1'b0;
      $display("rd addr=%h data=%h", a, v);
   endtask

   logic [31:0] v;
   logic [9:0]  a5_bits;
   int          rate;

   initial begin
      rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wstrb = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      sync();
      check("reset_txd", {31'h0, txd}, 32'h1);
      rd(32'h4, v); check("reset_status", v, 32'h004);
      rd(32'h8, v); check("reset_div", v, 32'd433);

      // DIV=3, single byte 0xA5
      sync();
      wr(32'h8, 32'd3, 4'b0011);
      wr(32'h0, 32'hA5, 4'b0001);
      check("a5_pre_fall", {31'h0, txd}, 32'h1);
      sync();
      check("a5_fall", {31'h0, txd}, 32'h0);
      sync();
      a5_bits = 10'b11010_01010;   // index k = bit k on the line: start, 1,0,1,0,0,1,0,1, stop
      for (int k = 0; k < 10; k++) begin
         check($sformatf("a5_bit%0d", k), {31'h0, txd}, {31'h0, a5_bits[k]});
         repeat (4) @(posedge clk);
         #1;
      end
      rd(32'h4, v); check("a5_status_done", v, 32'h004);

      // Back-to-back 0x55, 0x0F
      sync();
      wr(32'h0, 32'h55, 4'b0001);
      wr(32'h0, 32'h0F, 4'b0001);
      check("b2b_start1", {31'h0, txd}, 32'h0);
      repeat (39) @(posedge clk);
      #1;
      check("b2b_stop1_last", {31'h0, txd}, 32'h1);
      rd(32'h4, v); check("b2b_status_mid", v, 32'h0101);
      sync();
      check("b2b_start2", {31'h0, txd}, 32'h0);
      repeat (39) @(posedge clk);
      #1;
      check("b2b_stop2_last", {31'h0, txd}, 32'h1);
      rd(32'h4, v); check("b2b_status_busy", v, 32'h005);
      sync();
      rd(32'h4, v); check("b2b_status_idle", v, 32'h004);

      // Overflow with DIV=1000
      sync();
      wr(32'h8, 32'd1000, 4'b0011);
      for (int b = 0; b < 18; b++) wr(32'h0, b, 4'b0001);
      rd(32'h4, v); check("ovf_status", v, 32'h100B);
      wr(32'h4, 32'h08, 4'b0001);
      rd(32'h4, v); check("ovf_cleared", v, 32'h1003);
      wr(32'h8, 32'd0, 4'b0011);
      repeat (200) @(posedge clk);
      #1;
      rd(32'h4, v); check("ovf_drained", v, 32'h004);

      // DIV byte writes
      sync();
      wr(32'h8, 32'h0000_1234, 4'b0011);
      rd(32'h8, v); check("div_1234", v, 32'h1234);
      wr(32'h8, 32'h0000_00FF, 4'b0001);
      rd(32'h8, v); check("div_12ff", v, 32'h12FF);
      addr = 32'h8; ren = 1'b0; #1;
      check("rdata_no_ren", rdata, 32'h0);

      // Reset during data bit 3 with five bytes queued
      sync();
      wr(32'h8, 32'd3, 4'b0011);
      for (int b = 0; b < 6; b++) wr(32'h0, 32'h00, 4'b0001);
      repeat (12) @(posedge clk);
      #1;
      check("rst_pre_txd", {31'h0, txd}, 32'h0);
      #2 rst = 1'b1;
      #1;
      check("rst_async_txd", {31'h0, txd}, 32'h1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rd(32'h4, v); check("rst_status", v, 32'h004);
      rd(32'h8, v); check("rst_div", v, 32'd433);
      repeat (60) @(posedge clk);
      #1;
      check("rst_no_frames", {31'h0, txd}, 32'h1);
      rd(32'h4, v); check("rst_status_late", v, 32'h004);

      // Randomised traffic against the model
      sync();
      wr(32'h8, 32'd2, 4'b0011);
      rate = 5;
      for (int c = 0; c < 3000; c++) begin
         logic [1:0] s;
         if (c % 200 == 0) rate = $urandom_range(1, 9);
         s = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 3) s = 2'd0;
         addr      = $urandom();
         addr[3:2] = s;
         wdata     = $urandom();
         wstrb     = 4'($urandom());
         if (s == 2'd2) begin
            wdata[15:8] = 8'h0;
            wdata[7:0]  = 8'($urandom_range(0, 4));
         end
         if (s == 2'd1 && $urandom_range(0, 7) != 0) wdata[3] = 1'b0;
         wen = ($urandom_range(0, 9) < rate);
         ren = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      wen = 1'b0; ren = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the device side of the data-bus router, as a responder alongside the simulation device and data memory. It accepts byte writes from the CPU over the common bus (addr/ren/rdata/wen/wdata/wstrb) and buffers them in a TX FIFO. It serialises them as 8N1 frames on `txd` with a programmable baud divisor. Status and divisor registers are readable so software can poll before writing.

## Interface
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, 16'd433: reset value of DIV; one bit period = DIV+1 clocks.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  32  byte address from router; only `addr[3:2]` decoded.
- `ren`  in  1  read enable (router device select).
- `rdata`  out  32  read data; combinational.
- `wen`  in  1  write enable (router device select).
- `wdata`  in  32  write data.
- `wstrb`  in  4  byte write strobes.
- `txd`  out  1  serial output; idles high.

## Operation
- Register map (offset = `addr[3:2]`×4):
  - 0x00 TXDATA (W): `wen & wstrb[0]` pushes `wdata[7:0]`. Reads return 0.
  - 0x04 STATUS (R/W):
    - [0] busy (FSM ≠ IDLE); [1] full; [2] empty; [3] overflow (sticky); [15:8] FIFO count; other bits 0.
    - Write with `wstrb[0]` and `wdata[3]=1` clears overflow.
  - 0x08 DIV (R/W): bits[15:0], byte-writable via `wstrb[1:0]`; bits[31:16] read 0.
  - 0x0C: reads 0, writes ignored.
- `rdata` = selected register when `ren`, else 32'h0; it shares a bus and must not drive stale data.
- Simultaneous `ren`/`wen` to the same register: read returns the pre-write value.
- Push when full: byte dropped, overflow←1. Exception: the FSM pops in the same cycle, in which case the push is accepted.
- Overflow set and cleared in the same cycle: set wins.
- FIFO is circular with wrapping pointers; count ranges 0..FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP; bit counter 0..7; cycle counter `cnt`.
  - IDLE: `txd`=1. If FIFO non-empty: pop into shift register, `cnt`←0, go to START.
  - START: `txd`=0. When `cnt >= DIV`: `cnt`←0, go to DATA with bit index 0.
  - DATA: `txd`=shift[0], LSB first. At `cnt >= DIV`: shift right; after bit 7 go to STOP.
  - STOP: `txd`=1. At `cnt >= DIV`:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- A DIV write mid-frame takes effect immediately. The comparison is `>=`, so lowering DIV below the current `cnt` ends the current bit on the next cycle.
- DIV=0 is legal: one clock per bit.

## Timing
- Reset values:
  - `txd`=1; FSM IDLE; FIFO empty (count 0); overflow 0; DIV=DEFAULT_DIV.
  - `rdata` follows the combinational rule (0 when `ren`=0).
- `rst` asserted mid-frame: `txd` returns to 1 asynchronously and FIFO contents are discarded.
- Write latency, with empty FIFO and IDLE FSM:
  - TXDATA write is sampled at edge N.
  - The pop occurs at edge N+1, when `txd` falls.
- Frame length = 10×(DIV+1) clocks.
- Back-to-back frames: the next start bit begins on the edge that ends the stop bit.
- STATUS reflects registered state: empty/count update the edge after a push or pop; busy updates the edge after a state change.

## Test plan
- DIV=3, write 0xA5 to 0x00:
  - `txd` low from edge N+1 for 4 clocks.
  - Then 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks.
  - STATUS reads 0x004 (empty, not busy) after 40 clocks.
- DIV=3, write 0x55 then 0x0F on consecutive cycles:
  - Stop bit of the first frame is exactly 4 clocks and is immediately followed by the start bit of the second.
  - Total 80 clocks low-to-idle.
- DIV=1000, write bytes 0..17 on consecutive cycles:
  - Bytes 0–16 accepted (byte 0 popped on the 2nd cycle); byte 17 dropped.
  - STATUS = count 16, full=1, overflow=1.
  - Writing 0x08 to STATUS clears overflow; full stays 1.
- DIV writes:
  - 0x00001234 with `wstrb`=0011 reads back 0x00001234.
  - Then 0x000000FF with `wstrb`=0001 reads 0x000012FF.
  - `ren`=0 gives `rdata`=0.
- Assert `rst` during DATA bit 3 of a frame with 5 bytes queued:
  - `txd`=1 immediately.
  - After release, STATUS=0x004 and DIV=DEFAULT_DIV.
  - No further frames are transmitted.
